updown_counter_param: RTL and testbench

//   Parametrised up/down counter, the successor to the fixed 4-bit free-running counter.
//   It adds the following beyond that counter:
//   - programmable width and modulus;
//   - count enable and direction control;
//   - parallel load and synchronous clear;
//   - wrap or saturate mode;
//   - terminal-count and sticky-overflow outputs.

---
 rtl/updown_counter_param.sv | 95 +++++++++
 tb/tb_updown_counter_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// updown_counter_param
// Parametrised up/down event counter with parallel load, synchronous clear,
// wrap or saturate behaviour at the range ends, a combinational terminal-count
// strobe and a sticky overflow flag. Counting range is 0..MAX_VAL.
module updown_counter_param #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH - 1,
  parameter bit SATURATE  = 1'b0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,       // synchronous, active-low
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic             ovf_reg;
  logic             ovf_next;

  logic [WIDTH-1:0] eq_max_bits;
  logic             at_max;
  logic             at_zero;
  logic             bnd;
  logic [WIDTH-1:0] load_clamped;

  // Bitwise match of the count against the top value; all bits matching
  // means the counter sits on MAX_VAL.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_eq_max
      assign eq_max_bits[gi] = ~(cnt_reg[gi] ^ MAX_C[gi]);
    end
  endgenerate

  assign at_max  = &eq_max_bits;
  assign at_zero = ~|cnt_reg;

  // A boundary event is a count step that would leave the legal range; clear
  // and load take precedence, so they suppress it.
  assign bnd = en & ~clr & ~load & ((up & at_max) | (~up & at_zero));

  // Loads beyond the top of the range are pinned to MAX_VAL.
  assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;

  // Next-count and next-flag selection in priority order clr > load > en.
  always_comb begin
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (load) begin
      cnt_next = load_clamped;
    end else if (en) begin
      if (up) begin
        if (!at_max)       cnt_next = cnt_reg + ONE_C;
        else if (!SATURATE) cnt_next = '0;
      end else begin
        if (!at_zero)      cnt_next = cnt_reg - ONE_C;
        else if (!SATURATE) cnt_next = MAX_C;
      end
    end
    // Setting wins over clearing when both happen on the same edge.
    if (bnd)          ovf_next = 1'b1;
    else if (ovf_clr) ovf_next = 1'b0;
  end

  // State register; reset overrides every other control.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= RESET_C;
      ovf_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
    end
  end

  assign cnt = cnt_reg;
  assign ovf = ovf_reg;
  assign tc  = bnd & rst;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: one wrapping and one saturating
// instance (WIDTH=4, MAX_VAL=9) share the same stimulus.
module tb_updown_counter_param;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up;
  logic       ovf_clr;

  logic [3:0] cnt_w;
  logic       tc_w;
  logic       ovf_w;
  logic [3:0] cnt_s;
  logic       tc_s;
  logic       ovf_s;

  int checks = 0;
  int errors = 0;

  // Hand-computed vectors for the saturating down count and the direction test
  logic [3:0] dn_pre  [5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
  logic [3:0] dn_post [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
  logic       dir_up  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0] dir_cnt [5] = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd9};
  logic       dir_tc  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .ovf_clr(ovf_clr), .cnt(cnt_w), .tc(tc_w), .ovf(ovf_w)
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .RESET_VAL(0)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .ovf_clr(ovf_clr), .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic u, input logic oc);
    rst = r; clr = c; load = l; load_val = lv; en = e; up = u; ovf_clr = oc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // en=1, up=0 at cnt=0 is a boundary, but tc must stay low under reset
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (cnt_w !== 4'd0) begin errors++; $display("FAIL reset_cnt_w cyc%0d got %0d expected 0", i, cnt_w); end
      checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL reset_ovf_w cyc%0d got %0b expected 0", i, ovf_w); end
      checks++; if (tc_w !== 1'b0)  begin errors++; $display("FAIL reset_tc_w cyc%0d got %0b expected 0", i, tc_w); end
      checks++; if (cnt_s !== 4'd0) begin errors++; $display("FAIL reset_cnt_s cyc%0d got %0d expected 0", i, cnt_s); end
      $display("reset cycle %0d: cnt_w=%0d ovf_w=%0b tc_w=%0b", i, cnt_w, ovf_w, tc_w);
    end
  endtask

  task automatic test_up_count();
    logic [3:0] exp_cnt;
    exp_cnt = 4'd0;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (tc_w !== (exp_cnt == 4'd9)) begin errors++; $display("FAIL up_tc edge%0d got %0b expected %0b", i, tc_w, (exp_cnt == 4'd9)); end
      tick();
      exp_cnt = (exp_cnt == 4'd9) ? 4'd0 : exp_cnt + 4'd1;
      checks++; if (cnt_w !== exp_cnt) begin errors++; $display("FAIL up_cnt edge%0d got %0d expected %0d", i, cnt_w, exp_cnt); end
      checks++; if (ovf_w !== (i >= 9)) begin errors++; $display("FAIL up_ovf edge%0d got %0b expected %0b", i, ovf_w, (i >= 9)); end
      $display("up edge %0d: cnt_w=%0d tc_w(pre)=%0b ovf_w=%0b", i, cnt_w, (exp_cnt == 4'd0), ovf_w);
    end
    checks++; if (cnt_s !== 4'd9) begin errors++; $display("FAIL up_sat_hold got %0d expected 9", cnt_s); end
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL up_sat_ovf got %0b expected 1", ovf_s); end
  endtask

  task automatic test_down_saturate();
    // load 2 while clearing the sticky flag (load suppresses the boundary)
    drive(1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (tc_s !== 1'b0) begin errors++; $display("FAIL sat_load_tc got %0b expected 0", tc_s); end
    tick();
    checks++; if (cnt_s !== 4'd2) begin errors++; $display("FAIL sat_load_cnt got %0d expected 2", cnt_s); end
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL sat_load_ovf got %0b expected 0", ovf_s); end
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (tc_s !== (dn_pre[k] == 4'd0)) begin errors++; $display("FAIL sat_dn_tc edge%0d got %0b expected %0b", k, tc_s, (dn_pre[k] == 4'd0)); end
      tick();
      checks++; if (cnt_s !== dn_post[k]) begin errors++; $display("FAIL sat_dn_cnt edge%0d got %0d expected %0d", k, cnt_s, dn_post[k]); end
      checks++; if (ovf_s !== (k >= 2)) begin errors++; $display("FAIL sat_dn_ovf edge%0d got %0b expected %0b", k, ovf_s, (k >= 2)); end
      $display("sat down edge %0d: cnt_s=%0d ovf_s=%0b", k, cnt_s, ovf_s);
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL prio_clr_tc got %0b expected 0", tc_w); end
    tick();
    checks++; if (cnt_w !== 4'd0) begin errors++; $display("FAIL prio_clr_cnt_w got %0d expected 0", cnt_w); end
    checks++; if (cnt_s !== 4'd0) begin errors++; $display("FAIL prio_clr_cnt_s got %0d expected 0", cnt_s); end
    $display("priority clr+load: cnt_w=%0d cnt_s=%0d", cnt_w, cnt_s);
    drive(1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (cnt_w !== 4'd9) begin errors++; $display("FAIL prio_load9 got %0d expected 9", cnt_w); end
    // at MAX with en/up set, a load must mask tc; 15 clamps to 9
    drive(1'b1, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL prio_load_tc got %0b expected 0", tc_w); end
    tick();
    checks++; if (cnt_w !== 4'd9) begin errors++; $display("FAIL prio_clamp_w got %0d expected 9", cnt_w); end
    checks++; if (cnt_s !== 4'd9) begin errors++; $display("FAIL prio_clamp_s got %0d expected 9", cnt_s); end
    $display("priority load 15: cnt_w=%0d cnt_s=%0d", cnt_w, cnt_s);
  endtask

  task automatic test_sticky();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    tick();
    checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL sticky_clr got %0b expected 0", ovf_w); end
    $display("sticky clear: ovf_w=%0b", ovf_w);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (tc_w !== 1'b1) begin errors++; $display("FAIL sticky_tc got %0b expected 1", tc_w); end
    tick();
    checks++; if (ovf_w !== 1'b1) begin errors++; $display("FAIL sticky_setwins got %0b expected 1", ovf_w); end
    checks++; if (cnt_w !== 4'd0) begin errors++; $display("FAIL sticky_wrap_cnt got %0d expected 0", cnt_w); end
    $display("sticky set-wins: ovf_w=%0b cnt_w=%0d", ovf_w, cnt_w);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (cnt_w !== 4'd6) begin errors++; $display("FAIL rmid_load got %0d expected 6", cnt_w); end
    drive(1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL rmid_tc got %0b expected 0", tc_w); end
    tick();
    checks++; if (cnt_w !== 4'd0) begin errors++; $display("FAIL rmid_cnt got %0d expected 0", cnt_w); end
    checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %0b expected 0", ovf_w); end
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checks++; if (cnt_w !== 4'd1) begin errors++; $display("FAIL rmid_resume got %0d expected 1", cnt_w); end
    $display("reset mid-op: resumed cnt_w=%0d", cnt_w);
  endtask

  task automatic test_direction();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (cnt_w !== 4'd0) begin errors++; $display("FAIL dir_start got %0d expected 0", cnt_w); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, dir_up[k], 1'b0);
      #1;
      checks++; if (tc_w !== dir_tc[k]) begin errors++; $display("FAIL dir_tc edge%0d got %0b expected %0b", k, tc_w, dir_tc[k]); end
      tick();
      checks++; if (cnt_w !== dir_cnt[k]) begin errors++; $display("FAIL dir_cnt edge%0d got %0d expected %0d", k, cnt_w, dir_cnt[k]); end
      $display("dir edge %0d: up=%0b cnt_w=%0d", k, dir_up[k], cnt_w);
    end
    checks++; if (ovf_w !== 1'b1) begin errors++; $display("FAIL dir_ovf got %0b expected 1", ovf_w); end
    // hold at MAX with up=1: en=0 must keep tc low and cnt frozen
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL hold_tc edge%0d got %0b expected 0", k, tc_w); end
      tick();
      checks++; if (cnt_w !== 4'd9) begin errors++; $display("FAIL hold_cnt edge%0d got %0d expected 9", k, cnt_w); end
      $display("hold edge %0d: cnt_w=%0d", k, cnt_w);
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_saturate();
    test_priority();
    test_sticky();
    test_reset_mid();
    test_direction();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
